regfile32x64: RTL and testbench

REGFILE32X64 -- requirements
Module: regfile32x64

---
 rtl/regfile32x64_pkg.sv | 9 +
 rtl/regfile32x64_decoder.sv | 20 ++
 rtl/regfile32x64.sv | 85 ++++++++
 tb/tb_regfile32x64.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/regfile32x64_pkg.sv
// Shared sizing constants for the 32-entry register file and its write decoder.
package regfile32x64_pkg;

    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned ZERO_REG_IDX  = 31;
    localparam int unsigned DEFAULT_WIDTH = 64;

endpackage

// File: rtl/regfile32x64_decoder.sv
// 5-to-32 write-enable decoder; the zero-register bit can never be set.
module decoder5_32
    import regfile32x64_pkg::*;
#(
    parameter int unsigned ZERO_REG = ZERO_REG_IDX
) (
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [NUM_REGS-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile32x64.sv
// 32 x WIDTH register file: two combinational read ports with same-cycle write bypass,
// one write port, hard-wired zero register and synchronous reset.
module regfile32x64
    import regfile32x64_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned ZERO_REG = ZERO_REG_IDX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]      rd_data1,
    output logic [WIDTH-1:0]      rd_data2
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0]      regs [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_onehot;
    logic                  wr_live;
    logic [1:0][REG_ADDR_W-1:0] rd_addr_v;
    logic [1:0][WIDTH-1:0]      rd_data_v;

    // Reset gates the decoder so an in-flight write never lands on a reset edge.
    assign wr_live = wr_en & ~reset;

    decoder5_32 #(
        .ZERO_REG (ZERO_REG)
    ) u_dec (
        .en     (wr_live),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    assign rd_addr_v[0] = rd_addr1;
    assign rd_addr_v[1] = rd_addr2;
    assign rd_data1     = rd_data_v[0];
    assign rd_data2     = rd_data_v[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        // Heap-ordered binary mux tree: node k has children 2k+1 / 2k+2,
        // leaves occupy NUM_REGS-1 .. 2*NUM_REGS-2, root is selected by the MSB.
        logic [WIDTH-1:0] node [2*NUM_REGS-1];

        for (genvar j = 0; j < NUM_REGS; j++) begin : g_leaf
            assign node[NUM_REGS-1+j] = regs[j];
        end

        for (genvar d = 0; d < REG_ADDR_W; d++) begin : g_lvl
            for (genvar i = 0; i < (1 << d); i++) begin : g_node
                localparam int K = (1 << d) - 1 + i;
                assign node[K] = rd_addr_v[p][REG_ADDR_W-1-d] ? node[2*K+2] : node[2*K+1];
            end
        end

        always_comb begin
            if (rd_addr_v[p] == ZERO_ADDR) begin
                rd_data_v[p] = '0;
            end else if (wr_live && (wr_addr == rd_addr_v[p])) begin
                rd_data_v[p] = wr_data;
            end else begin
                rd_data_v[p] = node[0];
            end
        end
    end

endmodule

// File: tb/tb_regfile32x64.sv
// Randomised scoreboard bench for regfile32x64 against an array-based reference model.
module tb_regfile32x64;

    typedef struct {
        string       name;
        logic [63:0] exp1;
        logic [63:0] exp2;
        logic [31:0] exp_we;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;

    logic [63:0] model [32];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    regfile32x64 #(
        .WIDTH    (64),
        .ZERO_REG (31)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_read(input logic rst, input logic we,
                                             input logic [4:0] wa, input logic [63:0] wd,
                                             input logic [4:0] ra);
        if (ra == 5'd31) return 64'd0;
        if (!rst && we && wa == ra) return wd;
        return model[ra];
    endfunction

    // One cycle of stimulus: push the expected read/enable picture, then advance the model.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic check, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = ra1; rd_addr2 = ra2;
        if (check) begin
            e.name   = name;
            e.exp1   = ref_read(rst, we, wa, wd, ra1);
            e.exp2   = ref_read(rst, we, wa, wd, ra2);
            e.exp_we = (!rst && we && wa != 5'd31) ? (32'd1 << wa) : 32'd0;
            sb.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (we && wa != 5'd31) begin
            model[wa] = wd;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (rd_data1 !== e.exp1) begin
                    errors++;
                    $display("FAIL %0s rd_data1 got %h expected %h", e.name, rd_data1, e.exp1);
                end
                checks++;
                if (rd_data2 !== e.exp2) begin
                    errors++;
                    $display("FAIL %0s rd_data2 got %h expected %h", e.name, rd_data2, e.exp2);
                end
                checks++;
                if (dut.wr_onehot !== e.exp_we) begin
                    errors++;
                    $display("FAIL %0s decoder got %h expected %h", e.name, dut.wr_onehot, e.exp_we);
                end
            end
        end
    end

    initial begin : stimulus
        logic        rst, we;
        logic [4:0]  wa, ra1, ra2;
        logic [63:0] wd;
        int          wait_cycles;

        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, "init");

        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 1'b1, "reset_read_all");

        drive(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd5, 5'd6, 1'b1, "write_x5");
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd6, 1'b1, "read_x5_x6");

        drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1, "write_xzr_same");
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd5, 1'b1, "write_xzr_next");
        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(i), 1'b1, "xzr_no_change");

        drive(1'b0, 1'b0, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b1, "x7_wr_en0_old");
        drive(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b1, "x7_bypass");
        drive(1'b0, 1'b0, 5'd7, 64'h9999, 5'd7, 5'd7, 1'b1, "x7_wr_en0_hold");

        for (int i = 0; i < 31; i++)
            drive(1'b0, 1'b1, 5'(i), 64'(i + 1), 5'(i), 5'((i + 30) % 32), 1'b1, "fill_all");
        drive(1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd4, 1'b1, "reset_with_write");
        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'd3, 1'b1, "after_reset");
        drive(1'b0, 1'b1, 5'd3, 64'hABCD, 5'd3, 5'd2, 1'b1, "first_write_after_reset");
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd2, 1'b1, "first_write_visible");

        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = {$urandom, $urandom};
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
            drive(rst, we, wa, wd, ra1, ra2, 1'b1, "random");
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard left %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
